// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR burst arbiter: FSM states, grant
// encoding, write-FIFO word field positions and bus widths.
package ddr_arb_pkg;

  localparam int unsigned BURST_LEN   = 32;
  localparam int unsigned ADDR_W      = 29;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned USEDW_W     = 9;
  localparam int unsigned WR_HIGH_WM  = 384;
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned BCNT_W      = 7;
  localparam int unsigned BE_W        = 8;
  localparam int unsigned FIFO_W      = 96;

  // Write-FIFO word layout
  localparam int unsigned FLD_LAST    = 95;
  localparam int unsigned FLD_EOF     = 94;
  localparam int unsigned FLD_VALID   = 93;
  localparam int unsigned FLD_ADDR_HI = 92;
  localparam int unsigned FLD_ADDR_LO = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_CMD   = 2'd2,
    ST_RD_DATA  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_t;

endpackage

// File: rtl/ddr_burst_arbiter.sv
// Sole Avalon-MM master on the DDR port: drains the frame-write FIFO as fixed
// write bursts and interleaves read bursts, round-robin with a write watermark.
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
(
  input  logic                clk_100,
  input  logic                reset_n,
  input  logic [FIFO_W-1:0]   wr_fifo_q,
  input  logic [USEDW_W-1:0]  wr_fifo_usedw,
  input  logic                wr_fifo_empty,
  output logic                wr_fifo_rdreq,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_ack,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_data_valid,
  output logic                rd_burst_done,
  output logic                frame_wr_done,
  output logic                wr_sync_err,
  output logic [ADDR_W-1:0]   avl_address,
  output logic [BCNT_W-1:0]   avl_burstcount,
  output logic                avl_write,
  output logic                avl_read,
  output logic [DATA_W-1:0]   avl_writedata,
  output logic [BE_W-1:0]     avl_byteenable,
  input  logic                avl_waitrequest,
  input  logic [DATA_W-1:0]   avl_readdata,
  input  logic                avl_readdatavalid
);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  grant_t             last_grant;

  logic wr_elig;
  logic wr_accept;
  logic rd_accept;
  logic rd_beat;
  logic cnt_last;
  logic unused_valid;

  // The per-beat valid flag does not change burst framing; beats are written regardless
  assign unused_valid = wr_fifo_q[FLD_VALID];

  assign cnt_last  = (cnt == CNT_W'(BURST_LEN - 1));
  assign wr_accept = avl_write & ~avl_waitrequest;
  assign rd_accept = avl_read & ~avl_waitrequest;
  assign rd_beat   = (state == ST_RD_DATA) & avl_readdatavalid;
  assign wr_elig   = (wr_fifo_usedw >= USEDW_W'(BURST_LEN)) & ~wr_fifo_empty;

  // Show-ahead FIFO: pop in the same cycle the beat is taken by DDR
  assign wr_fifo_rdreq  = wr_accept;
  assign avl_writedata  = avl_write ? wr_fifo_q[DATA_W-1:0] : '0;
  assign avl_burstcount = BCNT_W'(BURST_LEN);
  assign avl_byteenable = '1;

  // Grant and burst sequencing
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (wr_elig && rd_req) begin
          if ((wr_fifo_usedw >= USEDW_W'(WR_HIGH_WM)) || (last_grant == GNT_RD)) begin
            state_nxt = ST_WR_BURST;
          end else begin
            state_nxt = ST_RD_CMD;
          end
        end else if (wr_elig) begin
          state_nxt = ST_WR_BURST;
        end else if (rd_req) begin
          state_nxt = ST_RD_CMD;
        end
      end
      ST_WR_BURST: begin
        if (wr_accept) begin
          if (cnt_last) begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_RD_CMD: begin
        if (rd_accept) begin
          state_nxt = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (rd_beat) begin
          if (cnt_last) begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= GNT_RD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == ST_WR_BURST && state_nxt == ST_IDLE) begin
        last_grant <= GNT_WR;
      end else if (state == ST_RD_DATA && state_nxt == ST_IDLE) begin
        last_grant <= GNT_RD;
      end
    end
  end

  // Command is launched from the next state so it lines up with the burst
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      avl_write     <= 1'b0;
      avl_read      <= 1'b0;
      avl_address   <= '0;
      rd_ack        <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      rd_burst_done <= 1'b0;
      frame_wr_done <= 1'b0;
      wr_sync_err   <= 1'b0;
    end else begin
      avl_write <= (state_nxt == ST_WR_BURST);
      avl_read  <= (state_nxt == ST_RD_CMD);
      if (state == ST_IDLE && state_nxt == ST_WR_BURST) begin
        avl_address <= wr_fifo_q[FLD_ADDR_HI:FLD_ADDR_LO];
      end else if (state == ST_IDLE && state_nxt == ST_RD_CMD) begin
        avl_address <= rd_addr;
      end
      rd_ack        <= rd_accept;
      rd_data_valid <= rd_beat;
      rd_burst_done <= rd_beat & cnt_last;
      if (rd_beat) begin
        rd_data <= avl_readdata;
      end
      frame_wr_done <= wr_accept & wr_fifo_q[FLD_EOF];
      if (wr_accept && (wr_fifo_q[FLD_LAST] != cnt_last)) begin
        wr_sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Randomized bench for ddr_burst_arbiter: FIFO, read requester and Avalon slave
// models plus a burst-level grant-order reference model.
module tb_ddr_burst_arbiter;
  import ddr_arb_pkg::*;

  logic        clk_100 = 1'b0;
  logic        reset_n = 1'b0;
  logic [95:0] wr_fifo_q;
  logic [8:0]  wr_fifo_usedw;
  logic        wr_fifo_empty;
  logic        wr_fifo_rdreq;
  logic        rd_req;
  logic [28:0] rd_addr;
  logic        rd_ack;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        rd_burst_done;
  logic        frame_wr_done;
  logic        wr_sync_err;
  logic [28:0] avl_address;
  logic [6:0]  avl_burstcount;
  logic        avl_write;
  logic        avl_read;
  logic [63:0] avl_writedata;
  logic [7:0]  avl_byteenable;
  logic        avl_waitrequest;
  logic [63:0] avl_readdata;
  logic        avl_readdatavalid;

  always #5 clk_100 = ~clk_100;

  ddr_burst_arbiter dut (
    .clk_100           (clk_100),
    .reset_n           (reset_n),
    .wr_fifo_q         (wr_fifo_q),
    .wr_fifo_usedw     (wr_fifo_usedw),
    .wr_fifo_empty     (wr_fifo_empty),
    .wr_fifo_rdreq     (wr_fifo_rdreq),
    .rd_req            (rd_req),
    .rd_addr           (rd_addr),
    .rd_ack            (rd_ack),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .rd_burst_done     (rd_burst_done),
    .frame_wr_done     (frame_wr_done),
    .wr_sync_err       (wr_sync_err),
    .avl_address       (avl_address),
    .avl_burstcount    (avl_burstcount),
    .avl_write         (avl_write),
    .avl_read          (avl_read),
    .avl_writedata     (avl_writedata),
    .avl_byteenable    (avl_byteenable),
    .avl_waitrequest   (avl_waitrequest),
    .avl_readdata      (avl_readdata),
    .avl_readdatavalid (avl_readdatavalid)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [95:0] fifo_m[$];
  logic [95:0] pushed[$];
  logic [28:0] rd_list[$];
  logic [63:0] exp_rd[$];
  bit          order_seen[$];

  int wr_idx, burst_base, wait_pct, rd_cmd_wait, rd_wait_cnt, rd_beats_left, rd_lat;
  int rd_beat_cnt, rd_ack_cnt, rd_done_cnt, rdreq_cnt, frame_cnt;
  int overlap_cnt, stab_viol, rdreq_viol, cyc, rd_start_cyc, first_rd_lat;
  int s_nwords, s_nreads, s_rwait;
  bit s_sync;
  bit p_pop, p_racc, p_wwait, p_rwait, p_eof;
  logic [28:0] p_addr;
  logic [63:0] p_wdata;

  task automatic chk_reset(input string tag);
    chk({tag, "_avl_write"},     64'(avl_write), 64'd0);
    chk({tag, "_avl_read"},      64'(avl_read), 64'd0);
    chk({tag, "_rdreq"},         64'(wr_fifo_rdreq), 64'd0);
    chk({tag, "_avl_address"},   64'(avl_address), 64'd0);
    chk({tag, "_avl_writedata"}, avl_writedata, 64'd0);
    chk({tag, "_rd_ack"},        64'(rd_ack), 64'd0);
    chk({tag, "_rd_data"},       rd_data, 64'd0);
    chk({tag, "_rd_valid"},      64'(rd_data_valid), 64'd0);
    chk({tag, "_rd_done"},       64'(rd_burst_done), 64'd0);
    chk({tag, "_frame_done"},    64'(frame_wr_done), 64'd0);
    chk({tag, "_sync_err"},      64'(wr_sync_err), 64'd0);
    chk({tag, "_burstcount"},    64'(avl_burstcount), 64'd32);
    chk({tag, "_byteenable"},    64'(avl_byteenable), 64'hFF);
  endtask

  // One clock: apply last cycle's transfers, drive the models, then sample
  task automatic cycle();
    @(posedge clk_100);
    #1;
    cyc++;
    if (p_pop && fifo_m.size() > 0) void'(fifo_m.pop_front());
    if (p_racc) begin
      rd_beats_left = BURST_LEN;
      rd_lat        = int'($urandom_range(0, 3));
      rd_wait_cnt   = 0;
    end
    if (rd_ack) begin
      rd_req = 1'b0;
      if (rd_list.size() > 0) void'(rd_list.pop_front());
    end else if (!rd_req && rd_list.size() > 0) begin
      rd_req  = 1'b1;
      rd_addr = rd_list[0];
    end
    wr_fifo_usedw = 9'(fifo_m.size());
    wr_fifo_empty = (fifo_m.size() == 0);
    wr_fifo_q     = (fifo_m.size() > 0) ? fifo_m[0] : '0;
    if (avl_read) begin
      avl_waitrequest = (rd_wait_cnt < rd_cmd_wait);
      rd_wait_cnt++;
    end else if (avl_write) begin
      avl_waitrequest = (int'($urandom_range(0, 99)) < wait_pct);
    end else begin
      avl_waitrequest = 1'b0;
    end
    avl_readdatavalid = 1'b0;
    if (rd_beats_left > 0) begin
      if (rd_lat > 0) rd_lat--;
      else if (int'($urandom_range(0, 99)) < 70) begin
        avl_readdatavalid = 1'b1;
        avl_readdata      = {$urandom, $urandom};
        exp_rd.push_back(avl_readdata);
        rd_beats_left--;
      end
    end else if (int'($urandom_range(0, 99)) < 5) begin
      avl_readdatavalid = 1'b1;
      avl_readdata      = {$urandom, $urandom};
    end
    #1;
    if (rd_data_valid) begin
      rd_beat_cnt++;
      if (exp_rd.size() > 0) chk("rd_data", rd_data, exp_rd.pop_front());
      else chk("rd_data_extra", 64'(rd_data_valid), 64'd0);
      chk("rd_burst_done", 64'(rd_burst_done), 64'(rd_beat_cnt == 32));
      if (rd_beat_cnt == 32) rd_beat_cnt = 0;
    end
    if (rd_burst_done) rd_done_cnt++;
    if (avl_read && rd_start_cyc < 0) rd_start_cyc = cyc;
    if (rd_ack) begin
      rd_ack_cnt++;
      if (first_rd_lat < 0) first_rd_lat = cyc - rd_start_cyc;
    end
    if (frame_wr_done || p_eof) chk("frame_wr_done", 64'(frame_wr_done), 64'(p_eof));
    if (frame_wr_done) frame_cnt++;
    if (avl_write && avl_read) overlap_cnt++;
    if (p_wwait && (!avl_write || avl_address != p_addr || avl_writedata != p_wdata)) stab_viol++;
    if (p_rwait && (!avl_read || avl_address != p_addr)) stab_viol++;
    if (wr_fifo_rdreq !== (avl_write && !avl_waitrequest)) rdreq_viol++;
    if (wr_fifo_rdreq) rdreq_cnt++;
    p_eof = 1'b0;
    if (avl_write && !avl_waitrequest) begin
      if (wr_idx < pushed.size()) begin
        if (wr_idx % 32 == 0) begin
          burst_base = wr_idx;
          order_seen.push_back(1'b1);
        end
        chk("wr_data", avl_writedata, pushed[wr_idx][63:0]);
        chk("wr_addr", 64'(avl_address), 64'(pushed[burst_base][92:64]));
        p_eof = pushed[wr_idx][94];
      end else begin
        chk("wr_extra", 64'(avl_write), 64'd0);
      end
      wr_idx++;
    end
    if (avl_read && !avl_waitrequest) begin
      order_seen.push_back(1'b0);
      if (rd_list.size() > 0) chk("rd_cmd_addr", 64'(avl_address), 64'(rd_list[0]));
      else chk("rd_extra", 64'(avl_read), 64'd0);
    end
    p_pop   = wr_fifo_rdreq;
    p_racc  = avl_read && !avl_waitrequest;
    p_wwait = avl_write && avl_waitrequest;
    p_rwait = avl_read && avl_waitrequest;
    p_addr  = avl_address;
    p_wdata = avl_writedata;
  endtask

  // Hold reset, preload FIFO and requester, check reset state, then release
  task automatic start_scn(input int nwords, input int nreads, input int wpct, input int rwait,
                           input int eof_mode, input bit sync_bad, input bit fixed_addr,
                           input logic [28:0] rbase);
    logic [28:0] cur_addr;
    logic [95:0] w;
    bit          lst, eof;
    reset_n = 1'b0;
    fifo_m.delete(); pushed.delete(); rd_list.delete(); exp_rd.delete(); order_seen.delete();
    cur_addr = '0;
    for (int i = 0; i < nwords; i++) begin
      if (i % 32 == 0) cur_addr = fixed_addr ? 29'(32'h100 + 32'(i)) : 29'($urandom);
      eof = (eof_mode == 1) ? (i % 32 == 31) :
            (eof_mode == 2) ? ((i % 32 == 31) && ($urandom_range(0, 1) == 1)) : 1'b0;
      lst = (sync_bad && i < 32) ? (i % 32 == 15) : (i % 32 == 31);
      w = {lst, eof, 1'b1, cur_addr, $urandom, $urandom};
      fifo_m.push_back(w);
      pushed.push_back(w);
    end
    for (int r = 0; r < nreads; r++) rd_list.push_back(rbase + 29'(r * 256));
    s_nwords = nwords; s_nreads = nreads; s_rwait = rwait; s_sync = sync_bad;
    wait_pct = wpct; rd_cmd_wait = rwait;
    wr_idx = 0; burst_base = 0; rd_wait_cnt = 0; rd_beats_left = 0; rd_lat = 0;
    rd_beat_cnt = 0; rd_ack_cnt = 0; rd_done_cnt = 0; rdreq_cnt = 0; frame_cnt = 0;
    overlap_cnt = 0; stab_viol = 0; rdreq_viol = 0; cyc = 0; rd_start_cyc = -1; first_rd_lat = -1;
    p_pop = 0; p_racc = 0; p_wwait = 0; p_rwait = 0; p_eof = 0; p_addr = '0; p_wdata = '0;
    wr_fifo_usedw     = 9'(fifo_m.size());
    wr_fifo_empty     = (fifo_m.size() == 0);
    wr_fifo_q         = (fifo_m.size() > 0) ? fifo_m[0] : '0;
    rd_req            = (nreads > 0);
    rd_addr           = (nreads > 0) ? rd_list[0] : '0;
    avl_waitrequest   = 1'b0;
    avl_readdatavalid = 1'b0;
    avl_readdata      = '0;
    @(posedge clk_100);
    #2;
    chk_reset("rst");
    reset_n = 1'b1;
  endtask

  // Run to completion and compare with the burst-level grant model
  task automatic run_and_check();
    bit model[$];
    int w, r, budget, exp_w, exp_eof;
    bit last_wr, pick_wr;
    w = s_nwords; r = s_nreads; last_wr = 1'b0;
    forever begin
      if (w < 32 && r == 0) break;
      if (w >= 32 && r > 0) pick_wr = (w >= 384) || !last_wr;
      else pick_wr = (w >= 32);
      if (pick_wr) w -= 32; else r--;
      last_wr = pick_wr;
      model.push_back(pick_wr);
    end
    exp_w = s_nwords - w;
    exp_eof = 0;
    for (int i = 0; i < exp_w; i++) if (pushed[i][94]) exp_eof++;
    budget = 0;
    while (!(wr_idx >= exp_w && rd_done_cnt >= s_nreads) && budget < 8000) begin
      cycle();
      budget++;
    end
    chk("finished_in_budget", 64'(budget < 8000), 64'd1);
    repeat (8) cycle();
    chk("burst_count", 64'(order_seen.size()), 64'(model.size()));
    for (int i = 0; i < model.size() && i < order_seen.size(); i++)
      chk("grant_order", 64'(order_seen[i]), 64'(model[i]));
    chk("wr_beats", 64'(wr_idx), 64'(exp_w));
    chk("rdreq_count", 64'(rdreq_cnt), 64'(exp_w));
    chk("rd_ack_count", 64'(rd_ack_cnt), 64'(s_nreads));
    chk("rd_done_count", 64'(rd_done_cnt), 64'(s_nreads));
    chk("frame_done_count", 64'(frame_cnt), 64'(exp_eof));
    chk("wr_sync_err", 64'(wr_sync_err), 64'(s_sync));
    chk("rw_overlap", 64'(overlap_cnt), 64'd0);
    chk("cmd_stable", 64'(stab_viol), 64'd0);
    chk("rdreq_rule", 64'(rdreq_viol), 64'd0);
    chk("fifo_left", 64'(fifo_m.size()), 64'(s_nwords - exp_w));
    chk("rd_beats_pending", 64'(exp_rd.size()), 64'd0);
    if (s_nreads > 0) chk("rd_ack_latency", 64'(first_rd_lat), 64'(s_rwait + 1));
  endtask

  initial begin
    int budget;
    rd_req = 1'b0; rd_addr = '0; wr_fifo_q = '0; wr_fifo_usedw = '0; wr_fifo_empty = 1'b1;
    avl_waitrequest = 1'b0; avl_readdata = '0; avl_readdatavalid = 1'b0;

    // Write only: bursts at 0x100 and 0x120
    start_scn(64, 0, 0, 0, 0, 1'b0, 1'b1, 29'h0);
    run_and_check();
    // Read only with 3 stalled command cycles
    start_scn(0, 1, 0, 3, 0, 1'b0, 1'b1, 29'h2000);
    run_and_check();
    // Contention below watermark: alternation starting with write
    start_scn(100, 2, 0, 1, 0, 1'b0, 1'b0, 29'h3000);
    run_and_check();
    // Watermark: writes win until usedw drops below 384
    start_scn(460, 2, 0, 0, 0, 1'b0, 1'b0, 29'h4000);
    run_and_check();
    // Frame end on beat 31 of each burst
    start_scn(64, 0, 20, 0, 1, 1'b0, 1'b1, 29'h0);
    run_and_check();
    // Last-beat flag on beat 15 of the first burst
    start_scn(64, 0, 0, 0, 0, 1'b1, 1'b1, 29'h0);
    run_and_check();
    // Randomized mixes with 30% write stalls
    for (int k = 0; k < 4; k++) begin
      start_scn(int'($urandom_range(0, 480)), int'($urandom_range(0, 4)), 30,
                int'($urandom_range(0, 3)), 2, 1'b0, 1'b0, 29'($urandom));
      run_and_check();
    end
    // Reset in the middle of a stalled write burst
    start_scn(64, 0, 30, 0, 0, 1'b0, 1'b1, 29'h0);
    budget = 0;
    while (wr_idx < 10 && budget < 500) begin
      cycle();
      budget++;
    end
    chk("midburst_reached", 64'(wr_idx >= 10), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    chk("mid_rw_overlap", 64'(overlap_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
